wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
//  Upstream/downstream controller for carry_select_adder: performs multi-precision addition of
//  operands streamed as W-bit limbs, least-significant limb first.
//  Issues each limb pair to the registered adder, chaining the adder carry_out into the next
//  limb's carry_in, and returns one sum limb per input limb on a valid/ready stream.
//  Adds a final carry on the last limb.
// PARAMETERS
//  W          64  limb width; must equal the attached adder width
//  MAX_LIMBS  16  max limbs per operation; IW = $clog2(MAX_LIMBS)
// PORTS
//  clock      in   1   clock
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   limb pair valid
//  in_ready   out  1   sequencer can accept a limb pair
//  in_a       in   W   operand A limb
//  in_b       in   W   operand B limb
//  in_cin     in   1   operation carry-in; sampled only on the first limb of an operation
//  in_last    in   1   marks the most-significant limb
//  add_a      out  W   to adder a
//  add_b      out  W   to adder b
//  add_cin    out  1   to adder carry_in
//  add_s      in   W   from adder s (registered in adder, 1-cycle latency)
//  add_cout   in   1   from adder carry_out (registered in adder)
//  out_valid  out  1   sum limb valid
//  out_ready  in   1   consumer accepts sum limb
//  out_sum    out  W   sum limb
//  out_idx    out  IW  limb index within the operation, 0 = LS limb
//  out_last   out  1   final limb of the operation
//  out_carry  out  1   carry out of this limb; final carry when out_last=1
//  out_trunc  out  1   operation force-terminated at MAX_LIMBS
//  busy       out  1   state != IDLE or operation in progress (first=0)
// BEHAVIOUR
//  - FSM IDLE -> EXEC -> RESP -> IDLE; throughput 1 limb per 3 cycles with out_ready held high.
//  - IDLE: in_ready=1, out_valid=0.
//    On in_valid&in_ready, register op_a<=in_a, op_b<=in_b, op_last<=in_last|(idx==MAX_LIMBS-1),
//    op_trunc<=~in_last&(idx==MAX_LIMBS-1), op_cin<=first?in_cin:carry_q; then go to EXEC.
//  - add_a/add_b/add_cin = op_a/op_b/op_cin at all times.
//    Adder inputs stay stable through EXEC and RESP, so add_s/add_cout remain valid while stalled.
//  - EXEC: single cycle (adder samples at its end); always -> RESP.
//  - RESP: out_valid=1; out_sum=add_s, out_carry=add_cout, out_last=op_last,
//    out_trunc=op_trunc, out_idx=idx. All outputs held stable until out_ready.
//  - RESP & out_ready: carry_q<=add_cout.
//    If op_last: first<=1, idx<=0. Else: first<=0, idx<=idx+1. Then -> IDLE.
//  - Latency: input handshake at edge E -> out_valid high in the cycle after edge E+1.
//  - in_ready=0 in EXEC and RESP; in_cin ignored when first=0.
//  - MAX_LIMBS boundary: limb index MAX_LIMBS-1 without in_last is treated as last (out_trunc=1).
//    The next limb starts a new operation (index 0, in_cin sampled).
//  - Single-limb op (in_last on first limb): out_idx=0, out_last=1.
//  - Reset (any state, mid-operation included): state=IDLE, first=1, idx=0, carry_q=0,
//    op_*=0, out_valid=0, out_trunc=0, busy=0. Adder shares reset; its outputs are 0 after reset.
//  - Arithmetic is exact modulo 2^(W*n) per limb; no saturation.
// TESTING
//  - 1 limb, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, out_carry=1, out_last=1, out_idx=0.
//  - 2 limbs, A={1,all-ones}, B={0,1}, cin=0 -> limb0 sum=0 carry=1; limb1 sum=2 carry=0 last=1.
//  - cin=1 on limb0 with a=b=0, then limb1 in_cin=0 (ignored) a=b=0 -> sums 1,0.
//  - out_ready low 5 cycles in RESP -> out_sum/out_carry/out_idx stable, in_ready=0;
//    then accepted, next limb uses the held carry.
//  - MAX_LIMBS limbs with in_last=0 -> limb MAX_LIMBS-1 has out_last=1, out_trunc=1;
//    the following limb has out_idx=0.
//  - Reset asserted in EXEC of limb 1 of a 3-limb op -> IDLE, busy=0;
//    a new op gives out_idx=0 and uses its own in_cin.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Limb sequencer for multi-precision addition through an externally registered adder.
// Each limb pair is issued, waits one cycle in the adder, and its sum is returned before the next limb is accepted.
module wide_add_sequencer #(
  parameter int W         = 64,
  parameter int MAX_LIMBS = 16,
  localparam int IW       = $clog2(MAX_LIMBS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_cin,
  input  logic          in_last,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  output logic          add_cin,
  input  logic [W-1:0]  add_s,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_carry,
  output logic          out_trunc,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_LIMBS - 1);

  state_t        state;
  logic          first;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic          op_last;
  logic          op_trunc;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  wire at_max = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      first       <= 1'b1;
      idx         <= '0;
      carry_q     <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_cin      <= 1'b0;
      op_last     <= 1'b0;
      op_trunc    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_a        <= in_a;
            op_b        <= in_b;
            op_cin      <= first ? in_cin : carry_q;
            // Running out of index space closes the operation even without in_last.
            op_last     <= in_last | at_max;
            op_trunc    <= ~in_last & at_max;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          out_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            carry_q     <= add_cout;
            if (op_last) begin
              first <= 1'b1;
              idx   <= '0;
            end else begin
              first <= 1'b0;
              idx   <= idx + IW'(1);
            end
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= ~op_last;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Operands stay parked on the adder so its registered result survives output stalls.
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign add_cin   = op_cin;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = add_s;
  assign out_carry = add_cout;
  assign out_idx   = idx;
  assign out_last  = op_last;
  assign out_trunc = op_trunc;
  assign busy      = busy_q;

endmodule
